// File: rtl/rb_controller.sv
// rb_controller: row-buffer controller producing RBS-tall window columns
// from a raster pixel stream.
//   clk, rst_n          : clock, async active-low reset
//   in_*_i / in_ready_o : pixel stream in (valid/ready, data, start of frame)
//   wr_*_o              : row-buffer write port (column, buffer select, pixel)
//   rd_en_o, rd_addr_o  : parallel read of all buffers at one column
//   rd_data_i           : read data, one cycle after rd_en_o
//   out_*               : window column out (valid/ready, lanes, column, eol/eof)
//   frame_done_o        : pulses when the last column of a frame is taken
//   sof_err_o           : sticky, start-of-frame seen in the middle of a frame
module rb_controller #(
  parameter int PIXEL_WIDTH = 8,
  parameter int RBS         = 4,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int ADDR_W      = $clog2(IMG_WIDTH),
  parameter int RB_W        = $clog2(RBS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [PIXEL_WIDTH-1:0]     in_data_i,
  input  logic                       in_sof_i,
  output logic                       wr_en_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [RB_W-1:0]            wr_rb_o,
  output logic [PIXEL_WIDTH-1:0]     wr_data_o,
  output logic                       rd_en_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  input  logic [RBS*PIXEL_WIDTH-1:0] rd_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [RBS*PIXEL_WIDTH-1:0] out_data_o,
  output logic [ADDR_W-1:0]          out_col_o,
  output logic                       out_eol_o,
  output logic                       out_eof_o,
  output logic                       frame_done_o,
  output logic                       sof_err_o
);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DW    = RBS * PIXEL_WIDTH;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [ADDR_W-1:0] col;
    logic              eol;
    logic              eof;
  } col_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [RB_W-1:0]    buf_q, buf_d;
  logic               rdy_en_q, sof_err_q;

  // read stage: one entry per streaming pixel whose buffer read is in flight
  logic               rd_vld_q;
  logic [PIXEL_WIDTH-1:0] rd_pix_q;
  logic [RB_W-1:0]    rd_rb_q;
  logic [ADDR_W-1:0]  rd_col_q;
  logic               rd_eol_q, rd_eof_q;
  col_t               rd_col;

  col_t               out_q, skid_q;
  logic               out_vld_q, skid_vld_q;

  logic               accept, proc, fire, pix_stream, last_col, last_row;
  logic [ADDR_W-1:0]  eff_col;
  logic [ROW_W-1:0]   eff_row;
  logic [RB_W-1:0]    eff_buf;
  logic [1:0]         occ;

  assign fire   = out_vld_q && out_ready_i;
  assign accept = in_valid_i && in_ready_o;
  // a sof pixel always restarts the frame position, whatever the state
  assign proc    = accept && ((state_q != IDLE) || in_sof_i);
  assign eff_col = in_sof_i ? '0 : col_q;
  assign eff_row = in_sof_i ? '0 : row_q;
  assign eff_buf = in_sof_i ? '0 : buf_q;
  assign pix_stream = int'(eff_row) >= RBS - 1;
  assign last_col   = int'(eff_col) == IMG_WIDTH - 1;
  assign last_row   = int'(eff_row) == IMG_HEIGHT - 1;

  // state register (frame position travels with the state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      buf_q     <= '0;
      rdy_en_q  <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      buf_q    <= buf_d;
      rdy_en_q <= 1'b1;
      if (accept && in_sof_i && state_q != IDLE) sof_err_q <= 1'b1;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    buf_d   = buf_q;
    if (proc) begin
      col_d = last_col ? '0 : eff_col + ADDR_W'(1);
      row_d = last_col ? eff_row + ROW_W'(1) : eff_row;
      if (last_col) buf_d = (int'(eff_buf) == RBS - 1) ? '0 : eff_buf + RB_W'(1);
      else          buf_d = eff_buf;
      if (last_col && last_row) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
        buf_d   = '0;
      end else if (int'(row_d) >= RBS - 1) begin
        state_d = STREAM;
      end else begin
        state_d = PRIME;
      end
    end
  end

  // outputs
  always_comb begin
    occ        = {1'b0, rd_vld_q} + {1'b0, out_vld_q} + {1'b0, skid_vld_q};
    in_ready_o = rdy_en_q && ((occ - {1'b0, fire}) < 2'd2);
    wr_en_o    = proc;
    wr_addr_o  = eff_col;
    wr_rb_o    = eff_buf;
    wr_data_o  = in_data_i;
    rd_en_o    = proc;
    rd_addr_o  = eff_col;
  end

  // window column: oldest row sits in the buffer after the one being written
  always_comb begin
    rd_col.data = '0;
    for (int j = 0; j < RBS - 1; j++)
      rd_col.data[j*PIXEL_WIDTH +: PIXEL_WIDTH] =
        rd_data_i[((int'(rd_rb_q) + 1 + j) % RBS)*PIXEL_WIDTH +: PIXEL_WIDTH];
    rd_col.data[(RBS-1)*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_pix_q;
    rd_col.col = rd_col_q;
    rd_col.eol = rd_eol_q;
    rd_col.eof = rd_eof_q;
  end

  // read stage -> output register, with a skid catching rd_data on a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_pix_q   <= '0;
      rd_rb_q    <= '0;
      rd_col_q   <= '0;
      rd_eol_q   <= 1'b0;
      rd_eof_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      rd_vld_q <= proc && pix_stream;
      if (proc) begin
        rd_pix_q <= in_data_i;
        rd_rb_q  <= eff_buf;
        rd_col_q <= eff_col;
        rd_eol_q <= last_col;
        rd_eof_q <= last_col && last_row;
      end
      if (!out_vld_q || fire) begin
        if (skid_vld_q) begin
          out_q      <= skid_q;
          out_vld_q  <= 1'b1;
          skid_vld_q <= rd_vld_q;
          if (rd_vld_q) skid_q <= rd_col;
        end else begin
          out_vld_q <= rd_vld_q;
          if (rd_vld_q) out_q <= rd_col;
        end
      end else if (rd_vld_q) begin
        skid_q     <= rd_col;
        skid_vld_q <= 1'b1;
      end
    end
  end

  assign out_valid_o  = out_vld_q;
  assign out_data_o   = out_q.data;
  assign out_col_o    = out_q.col;
  assign out_eol_o    = out_q.eol;
  assign out_eof_o    = out_q.eof;
  assign frame_done_o = fire && out_q.eof;
  assign sof_err_o    = sof_err_q;
endmodule

// File: tb/tb_rb_controller.sv
module tb_rb_controller;
  localparam int PW = 8, RBS = 4, W = 8, H = 6, AW = 3, RW = 2, DW = RBS*PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, in_sof, wr_en, rd_en, out_valid, out_ready;
  logic out_eol, out_eof, frame_done, sof_err;
  logic [PW-1:0] in_data, wr_data;
  logic [AW-1:0] wr_addr, rd_addr, out_col;
  logic [RW-1:0] wr_rb;
  logic [DW-1:0] rd_data, out_data;

  rb_controller #(.PIXEL_WIDTH(PW), .RBS(RBS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_sof_i(in_sof),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_rb_o(wr_rb), .wr_data_o(wr_data),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_col_o(out_col), .out_eol_o(out_eol), .out_eof_o(out_eof),
    .frame_done_o(frame_done), .sof_err_o(sof_err));

  // row-buffer RAMs: registered read, write in the same cycle
  logic [PW-1:0] rbmem [RBS][W];
  always @(posedge clk) begin
    if (rd_en) for (int b = 0; b < RBS; b++) rd_data[b*PW +: PW] <= rbmem[b][rd_addr];
    if (wr_en) rbmem[wr_rb][wr_addr] <= wr_data;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            col;
    bit            eol;
    bit            eof;
  } col_t;

  col_t expq[$];
  int checks = 0, errors = 0;
  // reference model: frame position, stored image, pending column count
  bit mactive, msof_err;
  int mrow, mcol, pending, since_rst, cyc;
  logic [PW-1:0] img [H][W];
  bit prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_col;
  logic prev_eol, prev_eof;
  // stats
  int nout, ndone, t30, tfirst;
  bit got_first, last_eof, last_acc;
  logic [DW-1:0] first_data, last_data;
  // drive values
  bit drv_valid, drv_sof, rand_ready;
  logic [PW-1:0] drv_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mreset();
    expq.delete();
    pending = 0; mactive = 0; msof_err = 0; mrow = 0; mcol = 0;
    prev_stall = 0; since_rst = 0;
  endtask

  task automatic reset_stats();
    nout = 0; ndone = 0; got_first = 0; t30 = -100; tfirst = 0;
  endtask

  task automatic sample();
    bit fire, acc, proc, exp_rdy;
    int pr, pc;
    col_t e;
    fire    = out_valid && out_ready;
    exp_rdy = (since_rst > 0) && ((pending - int'(fire)) < 2);
    chk("in_ready", in_ready, exp_rdy);
    acc  = in_valid && in_ready;
    proc = acc && (mactive || in_sof);
    pr = in_sof ? 0 : mrow;
    pc = in_sof ? 0 : mcol;
    chk("wr_en", wr_en, proc);
    chk("rd_en", rd_en, proc);
    if (proc) begin
      chk("wr_addr", wr_addr, pc);
      chk("rd_addr", rd_addr, pc);
      chk("wr_rb", wr_rb, pr % RBS);
      chk("wr_data", wr_data, in_data);
    end
    chk("sof_err", sof_err, msof_err);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
      chk("stall_col", out_col, prev_col);
      chk("stall_eol", out_eol, prev_eol);
      chk("stall_eof", out_eof, prev_eof);
    end
    if (out_valid) chk("valid_with_pending", pending > 0, 1);
    if (fire) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_column actual col=%0d expected none", out_col);
      end else begin
        e = expq.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_col", out_col, e.col);
        chk("out_eol", out_eol, e.eol);
        chk("out_eof", out_eof, e.eof);
        chk("frame_done", frame_done, e.eof);
      end
      nout++;
      if (!got_first) begin got_first = 1; first_data = out_data; tfirst = cyc; end
      last_data = out_data; last_eof = out_eof;
      if (frame_done) ndone++;
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_col = out_col; prev_eol = out_eol; prev_eof = out_eof;
    if (fire) pending--;
    if (proc) begin
      if (in_sof && mactive) msof_err = 1;
      mactive = 1;
      img[pr][pc] = in_data;
      if (pr == RBS-1 && pc == 0) t30 = cyc;
      if (pr >= RBS-1) begin
        for (int j = 0; j < RBS; j++) e.data[j*PW +: PW] = img[pr-(RBS-1)+j][pc];
        e.col = pc; e.eol = (pc == W-1); e.eof = e.eol && (pr == H-1);
        expq.push_back(e);
        pending++;
      end
      mcol = pc + 1; mrow = pr;
      if (mcol == W) begin
        mcol = 0; mrow++;
        if (mrow == H) begin mactive = 0; mrow = 0; end
      end
    end
    last_acc = acc;
    cyc++;
    if (rst_n) since_rst++;
  endtask

  task automatic step();
    @(negedge clk);
    in_valid = drv_valid; in_sof = drv_sof; in_data = drv_data;
    out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    #2;
    sample();
  endtask

  task automatic send_pixel(input logic [PW-1:0] d, input bit sof);
    drv_valid = 1; drv_sof = sof; drv_data = d;
    for (int k = 0; k < 64; k++) begin
      step();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1);
    drv_valid = 0; drv_sof = 0;
  endtask

  task automatic send_range(input int first, input int last, input bit sof_first);
    for (int i = first; i <= last; i++)
      send_pixel(PW'((i / W) * 16 + (i % W)), sof_first && (i == first));
  endtask

  task automatic drain();
    drv_valid = 0; drv_sof = 0;
    for (int k = 0; k < 300 && pending > 0; k++) step();
    chk("drain_pending", pending, 0);
    repeat (2) step();
  endtask

  task automatic frame_checks(input bit latency);
    chk("ncols", nout, 24);
    chk("first_col", first_data, 32'h30201000);
    chk("last_col", last_data, 32'h57473727);
    chk("last_eof", last_eof, 1);
    chk("frame_done_count", ndone, 1);
    if (latency) chk("first_latency", tfirst - t30, 2);
  endtask

  typedef struct {
    bit vld; bit sof; logic [PW-1:0] data;
    bit exp_wr; int exp_addr; int exp_rb;
  } vec_t;
  vec_t vt[5];

  initial begin
    rst_n = 0; in_valid = 0; in_sof = 0; in_data = 0; out_ready = 1;
    drv_valid = 1; drv_sof = 0; drv_data = 8'h5A; rand_ready = 0; cyc = 0;
    mreset(); reset_stats();
    repeat (2) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_sof_err", sof_err, 0);
    rst_n = 1;
    #1 chk("ready_before_edge", in_ready, 0);
    since_rst = 1;

    // IDLE drops pixels without sof; sof pixel starts at col 0 buffer 0
    vt[0] = '{1, 0, 8'hAA, 0, 0, 0};
    vt[1] = '{1, 0, 8'hBB, 0, 0, 0};
    vt[2] = '{0, 1, 8'h11, 0, 0, 0};
    vt[3] = '{1, 1, 8'h00, 1, 0, 0};
    vt[4] = '{1, 0, 8'h01, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      drv_valid = vt[i].vld; drv_sof = vt[i].sof; drv_data = vt[i].data;
      step();
      chk("tbl_wr_en", wr_en, vt[i].exp_wr);
      if (vt[i].exp_wr) begin
        chk("tbl_wr_addr", wr_addr, vt[i].exp_addr);
        chk("tbl_wr_rb", wr_rb, vt[i].exp_rb);
      end
    end
    // rest of that frame, no backpressure
    send_range(2, W*H-1, 0);
    drain();
    frame_checks(1);

    // same frame under random backpressure
    reset_stats(); rand_ready = 1;
    send_range(0, W*H-1, 1);
    drain();
    frame_checks(0);
    rand_ready = 0;

    // sof at row 3 col 5 restarts the frame
    reset_stats();
    send_range(0, 3*W+4, 1);
    send_range(0, W*H-1, 1);
    drain();
    chk("sof_err_set", sof_err, 1);
    chk("restart_ncols", nout, 5 + 24);
    chk("restart_done", ndone, 1);

    // reset in the middle of STREAM
    reset_stats();
    send_range(0, 4*W+3, 1);
    chk("pre_reset_valid", out_valid, 1);
    #1 rst_n = 0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    mreset();
    repeat (2) step();
    rst_n = 1; since_rst = 1;
    reset_stats();
    send_range(0, W*H-1, 1);
    drain();
    frame_checks(1);

    // random traffic against the model
    rand_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_sof   = mactive ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 3) == 0);
      drv_data  = PW'($urandom);
      step();
    end
    drain();
    chk("rand_queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rb_controller.md
RB_CONTROLLER -- requirements
Module: rb_controller

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter RBS, default 4, number of row buffers and window height.
REQ-003 SHALL have parameter IMG_WIDTH, default 640, pixels per row, equal to the row-buffer depth.
REQ-004 SHALL have parameter IMG_HEIGHT, default 480, rows per frame.
REQ-005 SHALL have parameters ADDR_W, default clog2(IMG_WIDTH), and RB_W, default clog2(RBS).
REQ-006 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 in_valid / in_ready  in / out  1  pixel-stream handshake
 in_data  in  PIXEL_WIDTH  raster-order pixel
 in_sof  in  1  marks first pixel of frame
 wr_en  out  1  row-buffer write enable
 wr_addr  out  ADDR_W  write column
 wr_rb  out  RB_W  write row-buffer select
 wr_data  out  PIXEL_WIDTH  write pixel
 rd_en  out  1  parallel read enable, all buffers
 rd_addr  out  ADDR_W  read column
 rd_data  in  RBS*PIXEL_WIDTH  read data, one cycle after rd_en
 out_valid / out_ready  out / in  1  window-column handshake
 out_data  out  RBS*PIXEL_WIDTH  column, lane 0 oldest row, lane RBS-1 newest
 out_col  out  ADDR_W  column of out_data
 out_eol / out_eof  out  1  last column of row / last column of frame
 frame_done  out  1  one-cycle pulse at frame end
 sof_err  out  1  sticky, sof seen mid-frame

Function
REQ-007 SHALL implement states IDLE, PRIME, STREAM; accepted pixel = in_valid && in_ready.
REQ-008 IDLE: accepted pixel without in_sof SHALL be dropped, with no write and no output; pixel with in_sof SHALL be processed as col 0, row 0, buffer 0, then PRIME.
REQ-009 Each processed pixel at column c SHALL, in the accept cycle, drive wr_en=1, wr_addr=c, wr_rb=current buffer, wr_data=in_data, rd_en=1, rd_addr=c.
REQ-010 Column counter SHALL wrap IMG_WIDTH-1 -> 0, then increment the row counter and advance the buffer (RBS-1 wraps to 0).
REQ-011 PRIME SHALL cover rows 0..RBS-2 with no output; after the last pixel of row RBS-2 the state SHALL become STREAM.
REQ-012 STREAM SHALL emit one column per pixel: lane j<RBS-1 = rd_data of buffer (wr_rb+1+j) mod RBS, lane RBS-1 = the incoming pixel, delayed to align; read data of the buffer being written SHALL be ignored.
REQ-013 out_valid SHALL first assert 2 cycles after acceptance with no backpressure (read stage, output register); full throughput of 1 column/cycle while out_ready=1.
REQ-014 Output SHALL contain an output register plus a one-entry skid holding rd_data when the output register is stalled; no column SHALL be lost or duplicated.
REQ-015 in_ready SHALL be 1 iff (read in flight + output register + skid occupancy), less 1 if out_valid&&out_ready, is < 2.
REQ-016 out_data/out_col/out_eol/out_eof SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 out_eol SHALL be 1 at col IMG_WIDTH-1; out_eof at col IMG_WIDTH-1 of row IMG_HEIGHT-1.
REQ-018 After the last pixel of row IMG_HEIGHT-1 the state SHALL return to IDLE; frame_done SHALL pulse the cycle the out_eof column is handshaken.
REQ-019 in_sof in PRIME or STREAM SHALL set sof_err, discard the current frame position, and process that pixel as col 0, row 0, buffer 0 in PRIME; columns already in the output pipeline SHALL still drain.
REQ-020 wr_en and rd_en SHALL be 0 in every cycle with no accepted processed pixel.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE, clear counters, pipeline, skid and sof_err, and drive in_ready=0, wr_en=0, rd_en=0, out_valid=0, frame_done=0, out_data/out_col/out_eol/out_eof=0.
REQ-022 in_ready SHALL assert the first clk edge after rst_n deassertion; reset mid-frame SHALL discard all in-flight columns.

Verification
REQ-023 RBS=4, IMG_WIDTH=8, IMG_HEIGHT=6, pixel=row*16+col, out_ready=1 -> rows 0-2 give no output; first out_data lanes {0x00,0x10,0x20,0x30} two cycles after pixel 0x30; 24 columns total, last column lanes {0x27,0x37,0x47,0x57} with out_eof=1, frame_done pulse.
REQ-024 Same frame, out_ready toggled 1-0-0-1 randomly -> identical 24-column sequence, in_ready never 1 with 2 entries pending, outputs stable under stall.
REQ-025 Pixels without in_sof in IDLE -> no wr_en, no output; following sof pixel starts at buffer 0, col 0.
REQ-026 in_sof at row 3 col 5 -> sof_err=1, pending columns drain, no output until 3 new rows primed.
REQ-027 rst_n low mid-STREAM with out_valid=1 -> out_valid=0 immediately; new frame after reset matches REQ-023.
REQ-028 Buffer-rotation check at rows 4..5 -> lane 0 always oldest row, wr_rb sequence 0,1,2,3,0,1.
